// File: rtl/sync_sink_r1_2ph.sv
// sync_sink_r1_2ph
// Receiver for a single-rail 2-phase request channel. Each transition of r is
// synchronised into clk, held as a valid/ready event with its bundled data, and
// acknowledged by toggling a once the consumer accepts it.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   r          2-phase request (each transition is one request)
//   a          2-phase acknowledge, driven straight from the phase flop
//   din        bundled data, stable from r transition until a transition
//   valid      event pending toward the clocked consumer (flop output)
//   ready      consumer accept, sampled only
//   dout       data captured for the pending event
//   ev_cnt     accepted-event count, wraps silently
//   proto_err  sticky 2-phase violation flag (request withdrawn before ack)
module sync_sink_r1_2ph #(
  parameter int SYNC_STAGES = 2,
  parameter int DW          = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r,
  output logic             a,
  input  logic [DW-1:0]    din,
  output logic             valid,
  input  logic             ready,
  output logic [DW-1:0]    dout,
  output logic [CNT_W-1:0] ev_cnt,
  output logic             proto_err
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   r_s;
  logic                   phase;
  logic                   load, accept, viol;

  // Only the first synchroniser flop ever sees raw r.
  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], r};
  end
  assign r_s = sync[SYNC_STAGES-1];

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    accept    = 1'b0;
    viol      = 1'b0;
    case (state)
      IDLE: begin
        if (r_s != phase) begin
          load      = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND: begin
        // A withdrawn request is flagged but the event is still delivered.
        if (r_s == phase) viol = 1'b1;
        if (ready) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= 1'b0;
      phase     <= 1'b0;
      dout      <= '0;
      ev_cnt    <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      // valid is registered alongside state so it never depends on ready
      // combinationally.
      valid <= (state_nxt == PEND);
      if (load)   dout <= din;
      if (accept) begin
        phase  <= ~phase;
        ev_cnt <= ev_cnt + CNT_W'(1);
      end
      if (viol) proto_err <= 1'b1;
    end
  end

  assign a = phase;

endmodule

// File: tb/tb_sync_sink_r1_2ph.sv
module tb_sync_sink_r1_2ph;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r = 1'b0;
  logic        ready = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        a, valid, proto_err;
  logic [7:0]  dout;
  logic [15:0] ev_cnt;
  logic        a4, valid4, proto_err4;
  logic [7:0]  dout4;
  logic [3:0]  ev_cnt4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_sink_r1_2ph #(.SYNC_STAGES(2), .DW(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .r(r), .a(a), .din(din), .valid(valid),
    .ready(ready), .dout(dout), .ev_cnt(ev_cnt), .proto_err(proto_err)
  );

  sync_sink_r1_2ph #(.SYNC_STAGES(2), .DW(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .r(r), .a(a4), .din(din), .valid(valid4),
    .ready(ready), .dout(dout4), .ev_cnt(ev_cnt4), .proto_err(proto_err4)
  );

  // Advance past the next rising edge; outputs are sampled 1ns after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; r = 1'b0; ready = 1'b0; din = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(3);
  endtask

  // Toggle r and wait (bounded) for a to follow, with ready held high.
  task automatic send_event(input logic [7:0] d, input string name);
    bit done;
    done = 1'b0;
    din = d; ready = 1'b1; r = ~r;
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (a === r) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s: a=%0b never matched r=%0b within 10 cycles", name, a, r);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; r = 1'b0; ready = 1'b0; din = 8'h00;
    tick(3);
    checks++; if (a !== 1'b0)      begin failures++; $display("FAIL reset_a: got %0b want 0", a); end
    checks++; if (valid !== 1'b0)  begin failures++; $display("FAIL reset_valid: got %0b want 0", valid); end
    checks++; if (ev_cnt !== 16'd0) begin failures++; $display("FAIL reset_ev_cnt: got %0d want 0", ev_cnt); end
    checks++; if (dout !== 8'h00)  begin failures++; $display("FAIL reset_dout: got %h want 00", dout); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL reset_proto_err: got %0b want 0", proto_err); end
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_single();
    din = 8'hA5; ready = 1'b1; r = 1'b1;
    tick(2); // edges 0,1
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL single_valid_early: got %0b want 0", valid); end
    tick();  // edge 2
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %0b want 1", valid); end
    checks++; if (dout !== 8'hA5) begin failures++; $display("FAIL single_dout: got %h want a5", dout); end
    checks++; if (a !== 1'b0)     begin failures++; $display("FAIL single_a_early: got %0b want 0", a); end
    tick();  // edge 3
    checks++; if (a !== 1'b1)     begin failures++; $display("FAIL single_a: got %0b want 1", a); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL single_valid_fall: got %0b want 0", valid); end
    checks++; if (ev_cnt !== 16'd1) begin failures++; $display("FAIL single_ev_cnt: got %0d want 1", ev_cnt); end
  endtask

  task automatic test_backpressure();
    ready = 1'b0; din = 8'h3C; r = 1'b0;
    tick(3);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL bp_valid_rise: got %0b want 1", valid); end
    din = 8'hFF; // only captured on the IDLE->PEND edge, so dout must not follow
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || dout !== 8'h3C || a !== 1'b1) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: valid=%0b dout=%h a=%0b want 1/3c/1", i, valid, dout, a);
      end
    end
    ready = 1'b1;
    tick();
    checks++; if (a !== 1'b0)     begin failures++; $display("FAIL bp_a_toggle: got %0b want 0", a); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL bp_valid_fall: got %0b want 0", valid); end
    checks++; if (ev_cnt !== 16'd2) begin failures++; $display("FAIL bp_ev_cnt: got %0d want 2", ev_cnt); end
    din = 8'h00;
  endtask

  task automatic test_two_phase();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    do_reset();
    for (int i = 0; i < 4; i++) send_event(vals[i], "twoph_ack");
    checks++; if (a !== 1'b0)       begin failures++; $display("FAIL twoph_a: got %0b want 0", a); end
    checks++; if (ev_cnt !== 16'd4) begin failures++; $display("FAIL twoph_ev_cnt: got %0d want 4", ev_cnt); end
    checks++; if (dout !== 8'h44)   begin failures++; $display("FAIL twoph_dout: got %h want 44", dout); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL twoph_proto_err: got %0b want 0", proto_err); end
  endtask

  task automatic test_violation();
    do_reset();
    ready = 1'b0; din = 8'h5A; r = 1'b1;
    tick(3);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL viol_valid: got %0b want 1", valid); end
    r = 1'b0; // withdrawn before acknowledge
    tick(3);
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL viol_flag: got %0b want 1", proto_err); end
    checks++; if (valid !== 1'b1 || dout !== 8'h5A) begin failures++; $display("FAIL viol_hold: valid=%0b dout=%h want 1/5a", valid, dout); end
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL viol_a_held: got %0b want 0", a); end
    ready = 1'b1;
    tick();
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL viol_a_toggle: got %0b want 1", a); end
    checks++; if (ev_cnt !== 16'd1) begin failures++; $display("FAIL viol_ev_cnt: got %0d want 1", ev_cnt); end
    ready = 1'b0;
    // r_s=0 now differs from phase=1, so a fresh event follows; flag stays.
    tick();
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL viol_next_valid: got %0b want 1", valid); end
    checks++; if (a !== 1'b1) begin failures++; $display("FAIL viol_single_toggle: got %0b want 1", a); end
    ready = 1'b1;
    tick();
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL viol_resync_a: got %0b want 0", a); end
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL viol_sticky: got %0b want 1", proto_err); end
    ready = 1'b0;
  endtask

  task automatic test_wrap_reset();
    do_reset();
    for (int i = 0; i < 16; i++) send_event(8'(i), "wrap_ack");
    checks++; if (ev_cnt4 !== 4'd0)  begin failures++; $display("FAIL wrap_ev_cnt4: got %0d want 0", ev_cnt4); end
    checks++; if (ev_cnt !== 16'd16) begin failures++; $display("FAIL wrap_ev_cnt16: got %0d want 16", ev_cnt); end
    ready = 1'b0; din = 8'hC3; r = 1'b1;
    tick(3);
    checks++; if (valid !== 1'b1) begin failures++; $display("FAIL midrst_valid_pre: got %0b want 1", valid); end
    rst = 1'b1; r = 1'b0;
    tick();
    checks++; if (valid !== 1'b0 || a !== 1'b0) begin failures++; $display("FAIL midrst_state: valid=%0b a=%0b want 0/0", valid, a); end
    checks++; if (ev_cnt !== 16'd0 || dout !== 8'h00) begin failures++; $display("FAIL midrst_regs: ev_cnt=%0d dout=%h want 0/00", ev_cnt, dout); end
    rst = 1'b0; ready = 1'b1;
    tick(5);
    checks++; if (a !== 1'b0 || valid !== 1'b0 || ev_cnt !== 16'd0) begin
      failures++; $display("FAIL midrst_no_ack: a=%0b valid=%0b ev_cnt=%0d want 0/0/0", a, valid, ev_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_two_phase();
    test_violation();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sync_sink_r1_2ph.md
# sync_sink_r1_2ph

Clocked receiver for a single-rail 2-phase request channel. It consumes the merged request `r`/`a` pair produced by the asynchronous request-merge stage. Each request transition is synchronised into the `clk` domain and presented to synchronous logic as a one-at-a-time valid/ready event with bundled data. The 2-phase acknowledge is toggled back only once the clocked consumer has accepted the event. The block is the boundary between the self-timed request network and the clocked datapath.

## Interface
Parameters:
- `SYNC_STAGES`, 2, synchroniser flops on `r`; legal range 2..4.
- `DW`, 8, width of bundled data captured with each request.
- `CNT_W`, 16, width of the accepted-event counter.

Ports:
- `clk`  in  1  single clock; all state is updated on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `r`  in  1  2-phase request; each transition (0→1 or 1→0) is one request.
- `a`  out  1  2-phase acknowledge; toggles once per accepted request; driven directly by a flop.
- `din`  in  DW  bundled data; stable from the `r` transition until the matching `a` transition.
- `valid`  out  1  event pending toward clocked consumer.
- `ready`  in  1  consumer accepts the event when `valid && ready` at a rising edge.
- `dout`  out  DW  data captured for the pending event.
- `ev_cnt`  out  CNT_W  number of accepted events, modulo 2^CNT_W.
- `proto_err`  out  1  sticky flag for a 2-phase protocol violation.

## Operation
- Synchroniser: `r` → `SYNC_STAGES` flops → `r_s`. No other logic samples raw `r`.
- `phase` register: the last acknowledged level; `a` is driven from `phase`. A request is pending when `r_s != phase`.
- FSM:
  - IDLE, `valid`=0. On an edge with `r_s != phase`: go to PEND and `dout <= din`.
  - PEND, `valid`=1. On an edge with `ready`=1: `phase <= ~phase` (toggles `a`), `ev_cnt <= ev_cnt+1`, go to IDLE.
  - PEND with `r_s == phase` (request withdrawn before acknowledge): set `proto_err`=1 and stay in PEND. `valid` and `dout` are held, and the event is still delivered and acknowledged normally.
- `dout` holds its value while in IDLE; it changes only on the IDLE→PEND edge.
- `ev_cnt` wraps from 2^CNT_W−1 to 0 without a flag.
- Only one request can be outstanding (2-phase rule), so no queueing is needed. The sender cannot toggle `r` again before it sees `a` toggle.
- `proto_err` clears only on `rst`.
- Reset: `rst`=1 at an edge forces `phase`=0, `a`=0, `valid`=0, FSM=IDLE, `dout`=0, `ev_cnt`=0, `proto_err`=0, and all synchroniser flops to 0.
- The upstream asynchronous network must be held in reset (r=0) for at least `SYNC_STAGES` cycles after `rst` deasserts. Any `r`=1 seen after reset is treated as a new request.
- Reset mid-operation: a pending event is discarded. No `a` toggle is produced for it, and `ev_cnt` is not incremented.

## Timing
- `r` transition before edge 0 → `r_s` changes after edge `SYNC_STAGES−1` → `valid` rises after edge `SYNC_STAGES`.
- With `ready` held at 1: `a` toggles and `valid` falls after edge `SYNC_STAGES+1`. Minimum request-to-ack latency is `SYNC_STAGES+2` edges.
- With `ready`=0: `valid` stays high and `dout` stays stable indefinitely. `a` toggles on the edge after `ready` rises.
- `valid` and `ready` are never combinationally dependent: `valid` comes from a flop and `ready` is only sampled.
- Back-to-back events: a new `valid` rises no earlier than `SYNC_STAGES+1` edges after the new `r` transition. `valid` is never high for two consecutive events without a low cycle in between.
- `rst` has priority over all other updates on the same edge.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `r`=0 → `a`=0, `valid`=0, `ev_cnt`=0, `dout`=0, `proto_err`=0.
- Single request, SYNC_STAGES=2, `ready`=1, `din`=0xA5: toggle `r` 0→1 → `valid`=1 after edge 2 with `dout`=0xA5; `a`=1 after edge 3; `ev_cnt`=1.
- Backpressure: `ready`=0 for 10 cycles after `valid` rises → `valid` and `dout` stable and `a` unchanged; raise `ready` → `a` toggles on the next edge.
- 2-phase sequence: `r` toggles 1→0→1→0, each only after `a` matches → four events accepted, `a` final value 0, `ev_cnt`=4, `proto_err`=0.
- Violation: toggle `r` twice before `a` responds (r=1 then back to 0 while in PEND) → `proto_err`=1 and stays set; the event still completes with a single `a` toggle.
- Wrap/reset: CNT_W=4, 16 events → `ev_cnt`=0. Assert `rst` while `valid`=1 → next cycle `valid`=0, `a`=0, and no extra `a` toggle.
